aes_decrypt: RTL and testbench

AES_DECRYPT -- requirements
Module: aes_decrypt

---
 rtl/aes_pkg.sv | 65 ++++++
 rtl/aes_inv_round.sv | 40 ++++
 rtl/aes_decrypt.sv | 70 +++++++
 tb/tb_aes_decrypt.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES inverse-cipher arithmetic: inverse S-box, GF(2^8) multipliers
// and the default key/round counts for AES-128.
package aes_pkg;

    localparam int NK_DEFAULT = 4;
    localparam int NR_DEFAULT = 10;

    localparam logic [7:0] INV_SBOX [256] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

    function automatic logic [7:0] inv_sbox(input logic [7:0] b);
        return INV_SBOX[b];
    endfunction

    // Multiply by x (0x02) modulo the AES polynomial
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] mul9(input logic [7:0] b);
        return xtime(xtime(xtime(b))) ^ b;
    endfunction

    function automatic logic [7:0] mul11(input logic [7:0] b);
        return xtime(xtime(xtime(b))) ^ xtime(b) ^ b;
    endfunction

    function automatic logic [7:0] mul13(input logic [7:0] b);
        return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ b;
    endfunction

    function automatic logic [7:0] mul14(input logic [7:0] b);
        return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ xtime(b);
    endfunction

    // InvMixColumns on one 32-bit column, row 0 in the MSBs
    function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        a0 = col[31:24];
        a1 = col[23:16];
        a2 = col[15:8];
        a3 = col[7:0];
        return {mul14(a0) ^ mul11(a1) ^ mul13(a2) ^ mul9(a3),
                mul9(a0)  ^ mul14(a1) ^ mul11(a2) ^ mul13(a3),
                mul13(a0) ^ mul9(a1)  ^ mul14(a2) ^ mul11(a3),
                mul11(a0) ^ mul13(a1) ^ mul9(a2)  ^ mul14(a3)};
    endfunction

endpackage

// File: rtl/aes_inv_round.sv
// One combinational inverse-cipher round: InvShiftRows, InvSubBytes,
// AddRoundKey, then InvMixColumns unless this is the final round.
module aes_inv_round
    import aes_pkg::*;
(
    input  logic [127:0] state_in,
    input  logic [127:0] round_key,
    input  logic         last_round,
    output logic [127:0] state_out
);

    logic [127:0] sub_s;
    logic [127:0] keyed_s;
    logic [127:0] mixed_s;

    // Byte i sits at row i%4, column i/4; row r rotates right by r columns
    for (genvar i = 0; i < 16; i++) begin : g_byte
        localparam int ROW = i % 4;
        localparam int COL = i / 4;
        localparam int SRC = ROW + 4 * ((COL - ROW + 4) % 4);
        assign sub_s[127 - 8 * i -: 8] = inv_sbox(state_in[127 - 8 * SRC -: 8]);
    end

    assign keyed_s = sub_s ^ round_key;

    for (genvar c = 0; c < 4; c++) begin : g_col
        assign mixed_s[127 - 32 * c -: 32] = inv_mix_col(keyed_s[127 - 32 * c -: 32]);
    end

    // The final round leaves out InvMixColumns
    always_comb begin
        state_out = keyed_s;
        if (last_round) begin
            state_out = keyed_s;
        end else begin
            state_out = mixed_s;
        end
    end

endmodule

// File: rtl/aes_decrypt.sv
// Fully pipelined AES inverse cipher: one register stage after the initial
// AddRoundKey and one per round, with a valid bit travelling beside each
// block. A full output that is not taken stalls the whole pipe; losing the
// key schedule flushes every in-flight block.
module aes_decrypt
    import aes_pkg::*;
#(
    parameter int Nk = NK_DEFAULT,
    parameter int Nr = NR_DEFAULT
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [127:0]          data_in,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [(Nr+1)*128-1:0] allKeys,
    input  logic                  key_ready,
    output logic [127:0]          out,
    output logic                  out_valid,
    input  logic                  out_ready
);

    if (Nr != Nk + 6) begin : g_cfg_check
        $error("aes_decrypt: Nr must equal Nk + 6");
    end

    logic [127:0] state_r [Nr+1];
    logic [Nr:0]  valid_r;
    logic [127:0] ark_s;
    logic [127:0] round_out_s [1:Nr];
    logic         stall_s;

    // Initial AddRoundKey uses the last schedule entry, found at the LSBs
    assign ark_s = data_in ^ allKeys[127:0];

    // Round i consumes key Nr-i, which lives at allKeys[(i+1)*128-1 -: 128]
    for (genvar i = 1; i <= Nr; i++) begin : g_round
        aes_inv_round u_round (
            .state_in   (state_r[i-1]),
            .round_key  (allKeys[(i+1)*128-1 -: 128]),
            .last_round ((i == Nr) ? 1'b1 : 1'b0),
            .state_out  (round_out_s[i])
        );
    end

    assign stall_s   = valid_r[Nr] & ~out_ready;
    assign in_ready  = key_ready & ~stall_s;
    assign out       = state_r[Nr];
    assign out_valid = valid_r[Nr];

    // Stage registers: clear on reset, flush valids on key loss, hold on stall
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_r <= {(Nr+1){1'b0}};
            for (int i = 0; i <= Nr; i++) begin
                state_r[i] <= 128'h0;
            end
        end else if (!key_ready) begin
            valid_r <= {(Nr+1){1'b0}};
        end else if (!stall_s) begin
            state_r[0] <= ark_s;
            valid_r[0] <= in_valid;
            for (int i = 1; i <= Nr; i++) begin
                state_r[i] <= round_out_s[i];
                valid_r[i] <= valid_r[i-1];
            end
        end
    end

endmodule

// File: tb/tb_aes_decrypt.sv
// Directed bench for aes_decrypt: FIPS-197 / SP800-38A vectors covering
// latency, back-to-back throughput, output stall, key flush and async reset.
module tb_aes_decrypt;

    localparam int NR = 10;

    // Expanded schedule for key 000102...0f, round key 0 first
    localparam logic [(NR+1)*128-1:0] SCHED_C1 = {
        128'h000102030405060708090a0b0c0d0e0f, 128'hd6aa74fdd2af72fadaa678f1d6ab76fe,
        128'hb692cf0b643dbdf1be9bc5006830b3fe, 128'hb6ff744ed2c2c9bf6c590cbf0469bf41,
        128'h47f7f7bc95353e03f96c32bcfd058dfd, 128'h3caaa3e8a99f9deb50f3af57adf622aa,
        128'h5e390f7df7a69296a7553dc10aa31f6b, 128'h14f9701ae35fe28c440adf4d4ea9c026,
        128'h47438735a41c65b9e016baf4aebf7ad2, 128'h549932d1f08557681093ed9cbe2c974e,
        128'h13111d7fe3944a17f307a78b4d2b30c5};

    // Expanded schedule for key 2b7e1516...4f3c
    localparam logic [(NR+1)*128-1:0] SCHED_A = {
        128'h2b7e151628aed2a6abf7158809cf4f3c, 128'ha0fafe1788542cb123a339392a6c7605,
        128'hf2c295f27a96b9435935807a7359f67f, 128'h3d80477d4716fe3e1e237e446d7a883b,
        128'hef44a541a8525b7fb671253bdb0bad00, 128'hd4d1c6f87c839d87caf2b8bc11f915bc,
        128'h6d88a37a110b3efddbf98641ca0093fd, 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
        128'head27321b58dbad2312bf5607f8d292f, 128'hac7766f319fadc2128d12941575c006e,
        128'hd014f9a8c9ee2589e13f0cc8b6630ca6};

    localparam logic [127:0] CT_C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] PT_C1 = 128'h00112233445566778899aabbccddeeff;

    logic                  clk = 1'b0;
    logic                  reset;
    logic [127:0]          data_in;
    logic                  in_valid;
    logic                  in_ready;
    logic [(NR+1)*128-1:0] all_keys;
    logic                  key_ready;
    logic [127:0]          out;
    logic                  out_valid;
    logic                  out_ready;

    logic [127:0] ct_a [5];
    logic [127:0] pt_a [5];

    int n_pass  = 0;
    int n_total = 0;

    aes_decrypt #(.Nk(4), .Nr(NR)) dut (
        .clk       (clk),
        .reset     (reset),
        .data_in   (data_in),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .allKeys   (all_keys),
        .key_ready (key_ready),
        .out       (out),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    // Free-running clock, 10 time-unit period
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_total++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one block, confirm it will be taken, and let the edge accept it
    task automatic send(input logic [127:0] d);
        data_in  = d;
        in_valid = 1'b1;
        #1;
        check_val("in_ready_on_send", {127'h0, in_ready}, 128'h1);
        step();
        in_valid = 1'b0;
    endtask

    // Count further edges until out_valid, bounded
    task automatic wait_out(output int n);
        n = 0;
        while (n < 40 && !out_valid) begin
            step();
            n++;
        end
    endtask

    // Directed sequence
    initial begin
        int n;
        int seen;
        ct_a[0] = 128'h3925841d02dc09fbdc118597196a0b32; pt_a[0] = 128'h3243f6a8885a308d313198a2e0370734;
        ct_a[1] = 128'h3ad77bb40d7a3660a89ecaf32466ef97; pt_a[1] = 128'h6bc1bee22e409f96e93d7e117393172a;
        ct_a[2] = 128'hf5d3d58503b9699de785895a96fdbaaf; pt_a[2] = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
        ct_a[3] = 128'h43b1cd7f598ece23881b00e3ed030688; pt_a[3] = 128'h30c81c46a35ce411e5fbc1191a0a52ef;
        ct_a[4] = 128'h7b0c785e27e8ad3f8223207104725dd4; pt_a[4] = 128'hf69f2445df4f9b17ad2b417be66c3710;

        reset     = 1'b0;
        key_ready = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        data_in   = 128'h0;
        all_keys  = SCHED_C1;
        repeat (3) step();
        check_val("reset_out", out, 128'h0);
        check_val("reset_out_valid", {127'h0, out_valid}, 128'h0);

        // Single block, latency from acceptance edge
        reset     = 1'b1;
        key_ready = 1'b1;
        send(CT_C1);
        wait_out(n);
        check_val("c1_latency", 128'(n + 1), 128'd11);
        check_val("c1_out", out, PT_C1);
        step();
        check_val("c1_drained", {127'h0, out_valid}, 128'h0);

        // Back-to-back blocks under one key
        all_keys = SCHED_A;
        for (int i = 0; i < 5; i++) send(ct_a[i]);
        wait_out(n);
        check_val("b2b_latency", 128'(n + 5), 128'd11);
        for (int i = 0; i < 5; i++) begin
            check_val("b2b_valid", {127'h0, out_valid}, 128'h1);
            check_val("b2b_out", out, pt_a[i]);
            step();
        end
        check_val("b2b_end", {127'h0, out_valid}, 128'h0);

        // Fill all 11 stages, then hold the output for 5 cycles
        out_ready = 1'b0;
        for (int j = 0; j < 11; j++) send(ct_a[j % 5]);
        check_val("stall_valid", {127'h0, out_valid}, 128'h1);
        check_val("stall_in_ready", {127'h0, in_ready}, 128'h0);
        data_in  = ct_a[2];
        in_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step();
            check_val("stall_hold_out", out, pt_a[0]);
            check_val("stall_hold_valid", {127'h0, out_valid}, 128'h1);
            check_val("stall_hold_in_ready", {127'h0, in_ready}, 128'h0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int j = 0; j < 11; j++) begin
            check_val("drain_valid", {127'h0, out_valid}, 128'h1);
            check_val("drain_out", out, pt_a[j % 5]);
            step();
        end
        check_val("drain_end", {127'h0, out_valid}, 128'h0);

        // Drop key_ready for one cycle with 4 blocks in flight
        for (int j = 0; j < 4; j++) send(ct_a[j + 1]);
        key_ready = 1'b0;
        #1;
        check_val("flush_in_ready", {127'h0, in_ready}, 128'h0);
        step();
        key_ready = 1'b1;
        send(ct_a[0]);
        wait_out(n);
        check_val("flush_latency", 128'(n + 1), 128'd11);
        check_val("flush_out", out, pt_a[0]);
        step();

        // Asynchronous reset with a stalled result and more in flight
        all_keys  = SCHED_C1;
        out_ready = 1'b0;
        for (int j = 0; j < 3; j++) send(CT_C1);
        wait_out(n);
        check_val("pre_reset_out", out, PT_C1);
        #2;
        reset = 1'b0;
        #1;
        check_val("async_reset_out", out, 128'h0);
        check_val("async_reset_valid", {127'h0, out_valid}, 128'h0);
        step();
        step();
        reset     = 1'b1;
        out_ready = 1'b1;
        send(CT_C1);
        wait_out(n);
        check_val("post_reset_latency", 128'(n + 1), 128'd11);
        check_val("post_reset_out", out, PT_C1);
        seen = 0;
        for (int k = 0; k < 12; k++) begin
            step();
            if (out_valid) seen++;
        end
        check_val("post_reset_no_leftovers", 128'(seen), 128'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
